// File: rtl/pc_pipeline.sv
// Program-counter pipeline: fetch PC generation plus per-stage PC/valid tracking
// with stall bubbles, branch redirect squash, misaligned-target flag and redirect count.
module pc_pipeline #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] START_ADDR     = '0,
  parameter int              DEPTH          = 4,
  parameter int              STALL_STAGE    = 1,
  parameter int              REDIRECT_STAGE = 2,
  parameter int              CNT_W          = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  redirect_valid_i,
  input  logic [XLEN-1:0]       redirect_target_i,
  output logic [XLEN-1:0]       fetch_pc_o,
  output logic [DEPTH*XLEN-1:0] stage_pc_o,
  output logic [DEPTH-1:0]      stage_valid_o,
  output logic                  misaligned_o,
  output logic [CNT_W-1:0]      redirect_count_o
);

  if (DEPTH < 3 || STALL_STAGE < 0 || STALL_STAGE >= REDIRECT_STAGE ||
      REDIRECT_STAGE > DEPTH - 1) begin : g_param_check
    $error("pc_pipeline: illegal DEPTH/STALL_STAGE/REDIRECT_STAGE combination");
  end

  logic [XLEN-1:0]  pc_q [DEPTH];
  logic [XLEN-1:0]  pc_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             hold;

  // A redirect only counts when the resolving stage holds a live instruction;
  // it also overrides any stall in the same cycle.
  assign accept = redirect_valid_i && valid_q[REDIRECT_STAGE];
  assign hold   = stall_i && !accept;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pc_d[i]    = pc_q[i];
      valid_d[i] = valid_q[i];
    end

    if (accept) begin
      pc_d[0] = {redirect_target_i[XLEN-1:2], 2'b00};
    end else if (!hold) begin
      pc_d[0] = pc_q[0] + XLEN'(4);
    end
    valid_d[0] = 1'b1;

    for (int i = 1; i < DEPTH; i++) begin
      if (!(hold && i <= STALL_STAGE)) begin
        pc_d[i]    = pc_q[i-1];
        valid_d[i] = valid_q[i-1];
        if (hold && i == STALL_STAGE + 1) valid_d[i] = 1'b0;
        if (accept && i <= REDIRECT_STAGE) valid_d[i] = 1'b0;
      end
    end

    mis_d = accept && (redirect_target_i[1:0] != 2'b00);
    cnt_d = cnt_q;
    if (accept && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q[0] <= START_ADDR;
      for (int i = 1; i < DEPTH; i++) pc_q[i] <= '0;
      valid_q <= DEPTH'(1);
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= pc_d[i];
      valid_q <= valid_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stage_pc_o[g*XLEN +: XLEN] = pc_q[g];
  end

  assign fetch_pc_o       = pc_q[0];
  assign stage_valid_o    = valid_q;
  assign misaligned_o     = mis_q;
  assign redirect_count_o = cnt_q;

endmodule
